// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared widths, opcodes and helpers for the execute-stage multiply/divide unit
package ex_mdu_pkg;
  localparam int REG_W = 32;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;
  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [2:0] EXE_RES_MOVE = 3'b011;
  function automatic logic [REG_W-1:0] neg_if(input logic [REG_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/mdu_div.sv
// mdu_div: radix-2 restoring divider on magnitudes with sign fix-up on the way out
module mdu_div
  import ex_mdu_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [REG_W-1:0] dividend_i,
  input  logic [REG_W-1:0] divisor_i,
  output logic [REG_W-1:0] quotient_o,
  output logic [REG_W-1:0] remainder_o,
  output logic             ready_o,
  output logic             stall_o
);
  localparam int CW = $clog2(DIV_ITERS + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic negq_q, negq_d, negr_q, negr_d, skip_q, skip_d;
  logic [REG_W:0] part, diff;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    skip_d  = 1'b0;
    stall_o = 1'b0;
    part    = {rem_q, quo_q[REG_W-1]};
    diff    = part - {1'b0, dvs_q};
    if (annul_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (start_i && !skip_q) begin
        stall_o = 1'b1;
        cnt_d   = '0;
        rem_d   = '0;
        negq_d  = signed_i & (dividend_i[REG_W-1] ^ divisor_i[REG_W-1]);
        negr_d  = signed_i & dividend_i[REG_W-1];
        quo_d   = neg_if(dividend_i, signed_i & dividend_i[REG_W-1]);
        dvs_d   = neg_if(divisor_i, signed_i & divisor_i[REG_W-1]);
        state_d = BUSY;
        // divide by zero skips the iterations: all-ones quotient, raw dividend as remainder
        if (divisor_i == ZERO_WORD) begin
          quo_d   = '1;
          rem_d   = dividend_i;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = DONE;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        rem_d   = diff[REG_W] ? part[REG_W-1:0] : diff[REG_W-1:0];
        quo_d   = {quo_q[REG_W-2:0], ~diff[REG_W]};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DIV_ITERS - 1) ? DONE : BUSY;
      end
      DONE: begin
        state_d = IDLE;
        skip_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      skip_q  <= skip_d;
    end
  end
  assign ready_o     = state_q == DONE && !annul_i;
  assign quotient_o  = neg_if(quo_q, negq_q);
  assign remainder_o = neg_if(rem_q, negr_q);
endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: execute-stage multiply/divide unit owning HI/LO, the MFHI/MFLO result path
// and the divide stall request
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       aluop_i,
  input  logic [2:0]       alusel_i,
  input  logic [REG_W-1:0] reg1_i,
  input  logic [REG_W-1:0] reg2_i,
  input  logic [4:0]       wd_i,
  input  logic             wreg_i,
  input  logic             annul_i,
  output logic [4:0]       wd_o,
  output logic             wreg_o,
  output logic [REG_W-1:0] wdata_o,
  output logic             stallreq_o,
  output logic [REG_W-1:0] hi_o,
  output logic [REG_W-1:0] lo_o
);
  logic [REG_W-1:0] hi_q, hi_d, lo_q, lo_d, quo, rem;
  logic [2*REG_W-1:0] prod;
  logic is_mult, is_mult_s, is_div, is_mf, div_ready, div_stall, unused_sel;
  assign unused_sel = ^alusel_i;
  assign is_mult_s  = aluop_i == EXE_MULT_OP;
  assign is_mult    = is_mult_s || aluop_i == EXE_MULTU_OP;
  assign is_div     = aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP;
  assign is_mf      = aluop_i == EXE_MFHI_OP || aluop_i == EXE_MFLO_OP;
  mdu_div #(.DIV_ITERS(DIV_ITERS)) u_div (
    .clk(clk), .rst(rst), .start_i(is_div), .signed_i(aluop_i == EXE_DIV_OP),
    .annul_i(annul_i), .dividend_i(reg1_i), .divisor_i(reg2_i),
    .quotient_o(quo), .remainder_o(rem), .ready_o(div_ready), .stall_o(div_stall)
  );
  always_comb begin
    // sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU
    prod = {{REG_W{is_mult_s & reg1_i[REG_W-1]}}, reg1_i} * {{REG_W{is_mult_s & reg2_i[REG_W-1]}}, reg2_i};
    hi_d = hi_q;
    lo_d = lo_q;
    if (annul_i) begin
      hi_d = hi_q;
    end else if (div_ready) begin
      hi_d = rem;
      lo_d = quo;
    end else if (is_mult) begin
      hi_d = prod[2*REG_W-1:REG_W];
      lo_d = prod[REG_W-1:0];
    end else begin
      hi_d = aluop_i == EXE_MTHI_OP ? reg1_i : hi_q;
      lo_d = aluop_i == EXE_MTLO_OP ? reg1_i : lo_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign wd_o       = rst ? 5'd0 : wd_i;
  assign wreg_o     = !rst && wreg_i && is_mf;
  assign wdata_o    = rst ? ZERO_WORD : aluop_i == EXE_MFHI_OP ? hi_q : aluop_i == EXE_MFLO_OP ? lo_q : ZERO_WORD;
  assign stallreq_o = !rst && div_stall;
  assign hi_o       = rst ? ZERO_WORD : hi_q;
  assign lo_o       = rst ? ZERO_WORD : lo_q;
endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Execute-stage multiply/divide unit. It consumes the ID/EX register outputs (aluop, alusel, operands, destination, write-enable) and owns the architectural HI/LO pair.
- Executes MULT/MULTU, DIV/DIVU, MFHI/MFLO and MTHI/MTLO.
- Requests a pipeline stall while an iterative divide is in flight.
- Results for MFHI/MFLO go to the EX/MEM register; the stall request goes to the pipeline controller, which freezes PC, IF/ID and ID/EX.

Parameters:
- DIV_ITERS, 32, quotient bits produced by the radix-2 restoring divider (one bit per cycle).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- aluop_i  input  8  operation subtype from ID/EX
- alusel_i  input  3  operation type from ID/EX
- reg1_i  input  32  operand 1 (rs; dividend, multiplicand, MTHI/MTLO source)
- reg2_i  input  32  operand 2 (rt; divisor, multiplier)
- wd_i  input  5  destination register address
- wreg_i  input  1  destination write request
- annul_i  input  1  flush; cancels an in-flight divide
- wd_o  output  5  destination address to EX/MEM
- wreg_o  output  1  write enable to EX/MEM
- wdata_o  output  32  result to EX/MEM
- stallreq_o  output  1  stall request to the pipeline controller
- hi_o  output  32  current HI (debug/observation)
- lo_o  output  32  current LO (debug/observation)

Behaviour:
- Reset: state=IDLE, HI=LO=0.
  - While rst=1: wd_o=0, wreg_o=0, wdata_o=0, stallreq_o=0, hi_o=lo_o=0.
  - Reset during a divide aborts it; HI/LO are not written.
- Output path (combinational from the inputs and the HI/LO registers):
  - wd_o=wd_i.
  - wreg_o = wreg_i AND (aluop is MFHI or MFLO).
  - wdata_o = HI for MFHI, LO for MFLO, 0 for every other aluop.
- MULT/MULTU: 32x32 product computed in a single cycle, no stall.
  - {HI,LO} <= product at the clock edge that ends the EX cycle.
  - MULT is signed two's-complement; MULTU is unsigned.
- MTHI: HI <= reg1_i at the end of the EX cycle. MTLO: LO <= reg1_i likewise. wreg_o=0 for both.
- An MFHI/MFLO following MULT/MTHI/MTLO/DIV reads the updated value, because the write completes before the next instruction's EX cycle. No bypass is required.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE with DIV/DIVU and annul_i=0:
    - Divisor == 0: go to DONE.
    - Otherwise: latch |dividend|, |divisor| (DIVU uses raw values), the quotient sign and the remainder sign; clear the counter; go to BUSY.
    - stallreq_o=1 in this cycle.
  - BUSY: one restoring step per cycle (shift, trial-subtract, keep or restore); counter++.
    - After DIV_ITERS steps, go to DONE.
    - stallreq_o=1 throughout.
  - DONE: stallreq_o=0. At this clock edge LO<=quotient and HI<=remainder, then go to IDLE.
    - The frozen pipeline holds the same DIV in ID/EX during DONE. The return to IDLE is qualified so the same DIV does not restart: IDLE ignores DIV/DIVU on the first cycle after DONE.
- Latency: non-zero divide stalls 1+DIV_ITERS=33 cycles, then one DONE cycle (34 EX cycles total). Divide by zero stalls 1 cycle.
- Sign fix-up (DIV):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps).
- Divide by zero: LO=0xFFFFFFFF, HI=reg1_i (both DIV and DIVU).
- annul_i=1 in any state: go to IDLE next cycle with no HI/LO write, and stallreq_o=0 in that cycle. Annul takes priority over DONE.
- Operands are sampled only on the IDLE to BUSY transition. Changes to reg1_i/reg2_i during BUSY are ignored.

Decomposition:
- Shared defines file (existing): RegBus, RegAddrBus, AluOpBus, AluSelBus, ZeroWord, WriteEnable/Disable, RstEnable.
- Added to the shared defines: EXE_MFHI_OP 8'b00010000, EXE_MTHI_OP 8'b00010001, EXE_MFLO_OP 8'b00010010, EXE_MTLO_OP 8'b00010011, EXE_MULT_OP 8'b00011000, EXE_MULTU_OP 8'b00011001, EXE_DIV_OP 8'b00011010, EXE_DIVU_OP 8'b00011011, EXE_RES_MOVE 3'b011.
- Divider FSM state encodings are local to the module.
- One sub-module: mdu_div (the iterative restoring divider: start, signed, annul, dividend, divisor -> quotient, remainder, ready). ex_mdu holds HI/LO, the output mux and the stall logic.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003, then MFHI/MFLO to r2/r3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA; wreg_o=1 with wdata_o matching. MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> stallreq_o high exactly 33 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU 5 / 0 -> 1 stall cycle; LO=0xFFFFFFFF, HI=0x00000005.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, MFHI, MFLO back-to-back -> wreg_o=0 on the MT* instructions; the MF* instructions return the written values with no stall.
- Start DIV, assert annul_i at BUSY cycle 10 -> stallreq_o=0 next cycle, HI/LO unchanged. Repeat with rst=1 mid-divide -> HI=LO=0, state IDLE, all outputs 0.
